// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
// Op encodings, FSM states and the default datapath width.
package ex_muldiv_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX
  } md_state_e;

endpackage

// File: rtl/ex_muldiv_core.sv
// One iteration of the muldiv datapath: shift-add multiply step
// or restoring divide step on a {upper, lower} accumulator.
module ex_muldiv_core #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]}
           + (acc[0] ? {1'b0, b} : '0);
    rem_sh = acc[2*WIDTH-1:WIDTH-1];
    diff   = rem_sh - {1'b0, b};
    if (is_div) begin
      // Borrow out means the trial subtract fails: keep remainder.
      if (diff[WIDTH])
        acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
        acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit with HI/LO registers.
// Runs magnitudes through the core and fixes signs at the end.
module ex_muldiv_unit
  import ex_muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             mf_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  md_state_e state;
  logic is_div;
  logic sgn;
  logic neg;
  logic rneg;
  logic dz;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;

  ex_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .acc      (acc),
    .b        (b_q),
    .is_div   (is_div),
    .acc_next (acc_next)
  );

  assign busy  = (state != S_IDLE);
  assign stall = busy & (start | mf_req | mthi | mtlo);

  always_comb begin
    abs_a = (sgn && a_q[WIDTH-1]) ? -a_q : a_q;
    abs_b = (sgn && b_q[WIDTH-1]) ? -b_q : b_q;
    prod  = neg ? -acc : acc;
    rem   = rneg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    // Divide by zero reports an all-ones quotient regardless of sign.
    if (dz)
      quo = '1;
    else
      quo = neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      cnt    <= '0;
      acc    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      is_div <= 1'b0;
      sgn    <= 1'b0;
      neg    <= 1'b0;
      rneg   <= 1'b0;
      dz     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= S_IDLE;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              a_q    <= rs_val;
              b_q    <= rt_val;
              is_div <= (op == MD_DIV) || (op == MD_DIVU);
              sgn    <= (op == MD_DIV) || (op == MD_MULT);
              state  <= S_PREP;
            end else begin
              if (mthi) hi <= wdata;
              if (mtlo) lo <= wdata;
            end
          end
          S_PREP: begin
            neg  <= sgn & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
            rneg <= sgn & a_q[WIDTH-1];
            dz   <= (b_q == '0);
            if (is_div) begin
              acc <= {{WIDTH{1'b0}}, abs_a};
              b_q <= abs_b;
            end else begin
              acc <= {{WIDTH{1'b0}}, abs_b};
              b_q <= abs_a;
            end
            cnt   <= CW'(WIDTH - 1);
            state <= S_RUN;
          end
          S_RUN: begin
            acc <= acc_next;
            cnt <= cnt - CW'(1);
            if (cnt == '0) state <= S_FIX;
          end
          S_FIX: begin
            if (is_div) begin
              hi <= rem;
              lo <= quo;
            end else begin
              hi <= prod[2*WIDTH-1:WIDTH];
              lo <= prod[WIDTH-1:0];
            end
            done  <= 1'b1;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: vector table, random ops
// against an arithmetic model, and hand-written control sequences.
module tb_ex_muldiv_unit;
  import ex_muldiv_pkg::*;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] rs_val;
  logic [W-1:0] rt_val;
  logic         flush;
  logic         mthi;
  logic         mtlo;
  logic [W-1:0] wdata;
  logic         mf_req;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         stall;
  logic         done;

  int tests = 0;
  int failed = 0;

  ex_muldiv_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .flush  (flush),
    .mthi   (mthi),
    .mtlo   (mtlo),
    .wdata  (wdata),
    .mf_req (mf_req),
    .hi     (hi),
    .lo     (lo),
    .busy   (busy),
    .stall  (stall),
    .done   (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa;
    longint sb;
    longint p;
    int     q;
    int     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: begin
        p = sa * sb;
        return p;
      end
      2'b01: return {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
          return {32'h0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (n < limit) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
    end
  endtask

  task automatic do_op(input logic [1:0] o,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       output logic [31:0] h,
                       output logic [31:0] l,
                       output int lat);
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(100, lat);
    h = hi;
    l = lo;
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (done) n++;
    end
  endtask

  initial begin
    logic [31:0] h;
    logic [31:0] l;
    logic [31:0] h0;
    logic [31:0] l0;
    logic [63:0] m;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    int lat;
    int n;
    int bad;

    vecs[0]  = '{MD_MULT,  32'hFFFFFFFD, 32'd7,
                 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1]  = '{MD_DIVU,  32'd100, 32'd7, 32'd2, 32'd14};
    vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'd2,
                 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{MD_DIVU,  32'h1234, 32'h0,
                 32'h1234, 32'hFFFFFFFF};
    vecs[4]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF,
                 32'h0, 32'h80000000};
    vecs[5]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 32'hFFFFFFFE, 32'h00000001};
    vecs[6]  = '{MD_DIV,   32'd7, 32'hFFFFFFFE,
                 32'd1, 32'hFFFFFFFD};
    vecs[7]  = '{MD_DIV,   32'hFFFFFFF8, 32'h0,
                 32'hFFFFFFF8, 32'hFFFFFFFF};
    vecs[8]  = '{MD_MULT,  32'h80000000, 32'h80000000,
                 32'h40000000, 32'h0};
    vecs[9]  = '{MD_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF,
                 32'hFFFFFFFF, 32'h80000001};
    vecs[10] = '{MD_MULTU, 32'h0, 32'h12345, 32'h0, 32'h0};

    rst = 1'b1; start = 1'b0; op = 2'b00;
    rs_val = '0; rt_val = '0; flush = 1'b0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0; mf_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hi", 64'(hi), 64'h0);
    check("reset_lo", 64'(lo), 64'h0);
    check("reset_busy", 64'(busy), 64'h0);
    check("reset_done", 64'(done), 64'h0);
    @(negedge clk) rst = 1'b0;

    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, h, l, lat);
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'(LAT));
      check($sformatf("vec%0d_hilo", i), {h, l},
            {vecs[i].eh, vecs[i].el});
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_once", i), 64'(done), 64'h0);
    end

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFFFFFF;
        default: rb = $urandom;
      endcase
      if (i % 6 == 5) ra = 32'($urandom_range(0, 255));
      m = model(ro, ra, rb);
      do_op(ro, ra, rb, h, l, lat);
      check($sformatf("rand%0d_op%0d_lat", i, ro), 64'(lat), 64'(LAT));
      check($sformatf("rand%0d_op%0d_%h_%h", i, ro, ra, rb),
            {h, l}, m);
    end

    // MTHI then MTLO while idle
    @(negedge clk); mthi = 1'b1; wdata = 32'hAAAA;
    @(negedge clk); mthi = 1'b0; mtlo = 1'b1; wdata = 32'h5555;
    @(negedge clk); mtlo = 1'b0;
    check("mthi_mtlo", {hi, lo}, {32'hAAAA, 32'h5555});

    // both written in the same cycle
    @(negedge clk); mthi = 1'b1; mtlo = 1'b1; wdata = 32'h1111;
    @(negedge clk); mthi = 1'b0; mtlo = 1'b0;
    check("mthi_mtlo_same", {hi, lo}, {32'h1111, 32'h1111});

    // mf_req during an op: stall every cycle, hi/lo frozen
    h0 = hi; l0 = lo;
    @(negedge clk);
    start = 1'b1; op = MD_DIVU; rs_val = 32'd1000; rt_val = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk); mf_req = 1'b1;
    bad = 0;
    n = 0;
    while (n < 100) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
      if (!stall || hi != h0 || lo != l0) bad++;
    end
    check("mf_stall_hold", 64'(bad), 64'h0);
    check("mf_lat", 64'(n), 64'(LAT));
    check("mf_result", {hi, lo}, {32'd1, 32'd333});
    check("mf_no_stall_idle", 64'(stall), 64'h0);
    @(negedge clk); mf_req = 1'b0;

    // flush in RUN cycle 10
    @(negedge clk); mthi = 1'b1; mtlo = 1'b1; wdata = 32'h2222;
    @(negedge clk); mthi = 1'b0; mtlo = 1'b0;
    start = 1'b1; op = MD_MULTU;
    rs_val = 32'hFFFFFFFF; rt_val = 32'hFFFFFFFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'h0);
    check("flush_hilo", {hi, lo}, {32'h2222, 32'h2222});
    count_done(40, n);
    check("flush_no_done", 64'(n), 64'h0);

    // flush with start while idle
    @(negedge clk); start = 1'b1; flush = 1'b1; op = MD_DIV;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_start_idle", 64'(busy), 64'h0);

    // start+mthi idle: start wins; start while busy ignored
    @(negedge clk);
    start = 1'b1; mthi = 1'b1; wdata = 32'hDEAD;
    op = MD_MULTU; rs_val = 32'd3; rt_val = 32'd5;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = MD_DIVU; rs_val = 32'd9; rt_val = 32'd2;
    #1;
    check("busy_start_stall", 64'(stall), 64'h1);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(100, n);
    check("busy_start_lat", 64'(n + 5), 64'(LAT));
    check("start_wins", {hi, lo}, {32'h0, 32'd15});

    // reset in the middle of a DIV
    do_op(MD_DIV, 32'hFFFFFF00, 32'd3, h, l, lat);
    @(negedge clk);
    start = 1'b1; op = MD_DIV; rs_val = 32'd77; rt_val = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_hilo", {hi, lo}, 64'h0);
    check("rst_mid_busy", 64'(busy), 64'h0);
    @(negedge clk); rst = 1'b0;
    count_done(40, n);
    check("rst_mid_no_done", 64'(n), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
